iter_muldiv: RTL and testbench



---
 rtl/iter_muldiv_if.sv | 29 ++
 rtl/iter_muldiv.sv | 169 ++++++++++++++++
 tb/tb_iter_muldiv.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/iter_muldiv_if.sv
// iter_muldiv_if: request/response bundle for the iterative multiply/divide unit.
//   Request : in_valid, in_ready, in_op[2:0] (RISC-V funct3), is_32bit (W-variant),
//             input_a / input_b (rs1 / rs2), flush (kill in-flight op).
//   Response: out_valid, out_ready, out_result.
//   master = pipeline side driving requests; slave = the unit itself.
interface iter_muldiv_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic            is_32bit;
  logic [XLEN-1:0] input_a;
  logic [XLEN-1:0] input_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid, in_op, is_32bit, input_a, input_b, flush, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, is_32bit, input_a, input_b, flush, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/iter_muldiv.sv
// iter_muldiv: multi-cycle radix-2 RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU, plus RV64 W-variants when enabled).
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : iter_muldiv_if.slave (request handshake, operands, flush, result handshake)
// Flow: IDLE (accept, operand prep) -> CALC (N iterations) -> FIX (sign/select) -> DONE.
// Divide-by-zero and signed overflow skip straight from IDLE to DONE.
module iter_muldiv #(
  parameter int XLEN  = 64,
  parameter bit W_OPS = 1'b1
) (
  input logic         clk,
  input logic         rst,
  iter_muldiv_if.slave bus
);
  localparam bit W_EN = (XLEN == 64) && W_OPS;
  localparam int CW   = $clog2(XLEN);
  localparam int PW   = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_reg, state_next;

  logic [CW-1:0]   cnt_reg;
  logic [2:0]      op_reg;
  logic            w_reg;
  logic            neg_reg;
  logic [XLEN-1:0] opa_reg;     // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0] opb_reg;     // multiplier bits (MSB first), or divisor
  logic [PW-1:0]   acc_reg;     // 2N-bit product
  logic [XLEN:0]   rem_reg;     // N+1-bit partial remainder
  logic [XLEN-1:0] result_reg;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // ---------------- operand prep at accept ----------------
  logic            accept, w_in, signed_a, signed_b, a_neg, b_neg, neg_in;
  logic            div_zero, ovf, special_in;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg, special_raw, special_res;

  assign bus.in_ready = (state_reg == IDLE) && !rst;
  // flush beats in_valid: nothing is latched in a flush cycle
  assign accept = bus.in_valid && bus.in_ready && !bus.flush;

  always_comb begin
    // Reserved W + MULH* combinations fall back to the full-width op.
    w_in     = W_EN && bus.is_32bit && (bus.in_op == 3'b000 || bus.in_op[2]);
    signed_a = (bus.in_op == 3'b000) || (bus.in_op == 3'b001) || (bus.in_op == 3'b010) ||
               (bus.in_op == 3'b100) || (bus.in_op == 3'b110);
    signed_b = (bus.in_op == 3'b000) || (bus.in_op == 3'b001) ||
               (bus.in_op == 3'b100) || (bus.in_op == 3'b110);
    a_ext = bus.input_a;
    b_ext = bus.input_b;
    if (w_in) begin
      a_ext = signed_a ? sext32(bus.input_a[31:0]) : XLEN'(bus.input_a[31:0]);
      b_ext = signed_b ? sext32(bus.input_b[31:0]) : XLEN'(bus.input_b[31:0]);
    end
    a_neg = signed_a && a_ext[XLEN-1];
    b_neg = signed_b && b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
    // REM takes the dividend's sign; everything else the xor of both signs
    neg_in = (bus.in_op[2] && bus.in_op[1]) ? a_neg : (a_neg ^ b_neg);

    min_neg    = w_in ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero   = bus.in_op[2] && (b_ext == '0);
    ovf        = bus.in_op[2] && !bus.in_op[0] && (a_ext == min_neg) && (b_ext == '1);
    special_in = div_zero || ovf;
    if (div_zero) special_raw = bus.in_op[1] ? a_ext : '1;
    else          special_raw = bus.in_op[1] ? '0 : a_ext;
    special_res = w_in ? sext32(special_raw[31:0]) : special_raw;
  end

  // ---------------- one radix-2 step ----------------
  logic            mul_bit, div_bit, q_bit;
  logic [PW-1:0]   acc_next;
  logic [XLEN+1:0] shifted, diff;
  logic [XLEN:0]   rem_next;
  logic [CW-1:0]   last_cnt;

  always_comb begin
    // W ops only consume the low 32 bits, so the "MSB" is bit 31
    mul_bit  = w_reg ? opb_reg[31] : opb_reg[XLEN-1];
    acc_next = (acc_reg << 1) + (mul_bit ? PW'(opa_reg) : '0);
    div_bit  = w_reg ? opa_reg[31] : opa_reg[XLEN-1];
    shifted  = {rem_reg, div_bit};
    diff     = shifted - {2'b00, opb_reg};
    q_bit    = !diff[XLEN+1];            // no borrow: divisor fits
    rem_next = q_bit ? diff[XLEN:0] : shifted[XLEN:0];
    last_cnt = w_reg ? CW'(31) : CW'(XLEN-1);
  end

  // ---------------- sign fix and result select ----------------
  logic [PW-1:0]   prod;
  logic [XLEN-1:0] quo, rmd, fix_raw, fix_res;

  always_comb begin
    prod = neg_reg ? -acc_reg : acc_reg;
    quo  = neg_reg ? -opa_reg : opa_reg;
    rmd  = neg_reg ? -rem_reg[XLEN-1:0] : rem_reg[XLEN-1:0];
    if (op_reg[2])               fix_raw = op_reg[1] ? rmd : quo;
    else if (op_reg[1:0] == 2'b00) fix_raw = prod[XLEN-1:0];
    else                         fix_raw = prod[PW-1:XLEN];
    fix_res = w_reg ? sext32(fix_raw[31:0]) : fix_raw;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = special_in ? DONE : CALC;
      CALC:    if (cnt_reg == last_cnt) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg    <= '0;
      op_reg     <= '0;
      w_reg      <= 1'b0;
      neg_reg    <= 1'b0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          cnt_reg <= '0;
          op_reg  <= bus.in_op;
          w_reg   <= w_in;
          neg_reg <= neg_in;
          opa_reg <= a_mag;
          opb_reg <= b_mag;
          acc_reg <= '0;
          rem_reg <= '0;
          if (special_in) result_reg <= special_res;
        end
        CALC: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (op_reg[2]) begin
            opa_reg <= {opa_reg[XLEN-2:0], q_bit};
            rem_reg <= rem_next;
          end else begin
            acc_reg <= acc_next;
            opb_reg <= opb_reg << 1;
          end
        end
        FIX:     result_reg <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.out_valid  = (state_reg == DONE);
  assign bus.out_result = result_reg;
endmodule

// File: tb/tb_iter_muldiv.sv
module tb_iter_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iter_muldiv_if #(.XLEN(64)) bus ();
  iter_muldiv #(.XLEN(64), .W_OPS(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];
  int          lat_q[$];
  string       nm_q[$];
  bit          seen = 1'b0;
  bit          chk_ready_next = 1'b0;
  logic [63:0] held = '0;
  string       cur_nm = "";

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%016h, required 0x%016h", nm, act, req);
  endtask

  // accept-edge timestamp for latency measurement
  always @(posedge clk) begin
    cyc++;
    if (!rst && bus.in_valid && bus.in_ready && !bus.flush) accept_cyc = cyc;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
      chk_ready_next = 1'b0;
    end else begin
      if (chk_ready_next) begin
        chk({cur_nm, " in_ready_after_hs"}, 64'(bus.in_ready), 64'd1);
        chk_ready_next = 1'b0;
      end
      if (bus.out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
          end else begin
            cur_nm = nm_q.pop_front();
            chk({cur_nm, " result"}, bus.out_result, exp_q.pop_front());
            chk({cur_nm, " latency"}, 64'(cyc - accept_cyc + 1), 64'(lat_q.pop_front()));
            held = bus.out_result;
          end
        end else begin
          chk({cur_nm, " result_stable"}, bus.out_result, held);
          chk({cur_nm, " in_ready_busy"}, 64'(bus.in_ready), 64'd0);
        end
        if (bus.out_ready) begin
          seen = 1'b0;
          done_cnt++;
          chk_ready_next = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input bit w, input logic [63:0] a, input logic [63:0] b);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) chk("send_in_ready_timeout", 64'd0, 64'd1);
    bus.in_op    = op;
    bus.is_32bit = w;
    bus.input_a  = a;
    bus.input_b  = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic issue(input string nm, input logic [2:0] op, input bit w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat, input bit bp);
    int start = done_cnt;
    int n = 0;
    exp_q.push_back(exp);
    lat_q.push_back(lat);
    nm_q.push_back(nm);
    if (bp) bus.out_ready = 1'b0;
    send(op, w, a, b);
    if (bp) begin
      while (!bus.out_valid && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      repeat (5) @(posedge clk);
      #1 bus.out_ready = 1'b1;
    end
    n = 0;
    while (done_cnt == start && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == start) begin
      chk({nm, " timeout"}, 64'd0, 64'd1);
      exp_q.delete();
      lat_q.delete();
      nm_q.delete();
      bus.out_ready = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'b000;
    bus.is_32bit  = 1'b0;
    bus.input_a   = '0;
    bus.input_b   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst out_result", bus.out_result, 64'd0);
    rst = 1'b0;
    #1 chk("in_ready after rst", 64'(bus.in_ready), 64'd1);

    issue("mul_7x-3",      3'b000, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, 0);
    issue("mulh_-5x3",     3'b001, 0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
    issue("mulhu_max",     3'b011, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
    issue("mulhsu_-1x2",   3'b010, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
    issue("mulhsu_2xmax",  3'b010, 0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 66, 0);
    issue("mulhu_resv_w",  3'b011, 1, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 66, 0);
    issue("mulw_7fff_x2",  3'b000, 1, 64'h1234_5678_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0);
    issue("div_5/0",       3'b100, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    issue("rem_5/0",       3'b110, 0, 64'd5, 64'd0, 64'd5, 1, 0);
    issue("div_ovf",       3'b100, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 0);
    issue("rem_ovf",       3'b110, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
    issue("divw_ovf",      3'b100, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
    issue("remuw_by0",     3'b111, 1, 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0005, 1, 0);
    issue("divw_-7/2",     3'b100, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, 0);
    issue("remw_-7/2",     3'b110, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
    issue("divuw_1ffff/1", 3'b101, 1, 64'h1_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
    issue("div_min/1",     3'b100, 0, 64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 66, 0);
    issue("div_-20/6_bp",  3'b100, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1);
    issue("rem_-20/6",     3'b110, 0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
    issue("remu_100/7",    3'b111, 0, 64'd100, 64'd7, 64'd2, 66, 0);

    // flush at CALC iteration 10: no result may appear
    send(3'b101, 0, 64'd1000, 64'd3);
    repeat (10) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush out_valid", 64'(bus.out_valid), 64'd0);
    repeat (80) @(posedge clk);
    #1;
    issue("divu_100/7_after_flush", 3'b101, 0, 64'd100, 64'd7, 64'd14, 66, 0);

    // same with reset in place of flush
    send(3'b101, 0, 64'd1000, 64'd3);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midop rst in_ready", 64'(bus.in_ready), 64'd0);
    chk("midop rst out_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;
    #1 chk("midop rst released in_ready", 64'(bus.in_ready), 64'd1);
    repeat (80) @(posedge clk);
    #1;
    issue("divu_100/7_after_rst", 3'b101, 0, 64'd100, 64'd7, 64'd14, 66, 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
